pipe_stage_chain: RTL and testbench
===================================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the payload width carried per stage.
REQ-002 The module SHALL have parameter STAGES, default 5, giving the number of chained stage registers; STAGES < 2 SHALL be a elaboration error.
REQ-003 The module SHALL have parameter CNT_W, default 32, giving the retired-counter width.
REQ-004 The module SHALL have a port: clk  in  1  sole clock, rising edge.
REQ-005 The module SHALL have a port: reset  in  1  synchronous, active-high reset.
REQ-006 The module SHALL have a port: in_valid  in  1  payload present at stage-0 input.
REQ-007 The module SHALL have a port: in_data  in  DATA_W  stage-0 payload (e.g. PC).
REQ-008 The module SHALL have a port: in_ready  out  1  stage 0 will capture this cycle.
REQ-009 The module SHALL have a port: freeze  in  STAGES  bit i requests stage i to hold.
REQ-010 The module SHALL have a port: flush  in  1  flush request.
REQ-011 The module SHALL have a port: flush_depth  in  $clog2(STAGES+1)  number of youngest stages (0..STAGES) to clear.
REQ-012 The module SHALL have a port: out_valid  out  1  valid of stage STAGES-1.
REQ-013 The module SHALL have a port: out_data  out  DATA_W  payload of stage STAGES-1.
REQ-014 The module SHALL have a port: occupancy  out  $clog2(STAGES+1)  count of valid stages.
REQ-015 The module SHALL have a port: retired_cnt  out  CNT_W  count of items leaving stage STAGES-1.

Function
REQ-016 hold[i] SHALL equal OR of freeze[j] for all j >= i, so a frozen stage holds itself and every older-input (lower-index) stage.
REQ-017 in_ready SHALL equal NOT hold[0]; it is combinational and does not depend on in_valid.
REQ-018 When NOT hold[0], stage 0 SHALL load valid=in_valid and data=in_data at the clock edge.
REQ-019 When NOT hold[i] for i >= 1, stage i SHALL load valid and data from stage i-1, except that when hold[i-1] is set it SHALL load valid=0 (a bubble) and keep its data.
REQ-020 When hold[i] is set, stage i SHALL keep both valid and data unchanged.
REQ-021 Data registers SHALL update only on advance; clearing or bubbling SHALL affect only valid bits.
REQ-022 With flush=1, stages 0..flush_depth-1 SHALL have valid=0 after the edge, with priority over hold and load; stages at flush_depth and above SHALL behave per REQ-018..REQ-020.
REQ-023 flush with flush_depth=0 SHALL be a no-op, and flush_depth >= STAGES SHALL clear all stages.
REQ-024 An in_data captured in a cycle that flushes stage 0 SHALL be discarded, while in_ready still follows REQ-017.
REQ-025 Latency SHALL be exactly STAGES cycles with no freeze: an item accepted in cycle n appears on out_valid/out_data in cycle n+STAGES.
REQ-026 A retire event SHALL be out_valid AND NOT freeze[STAGES-1], and it SHALL be counted even if flush clears stage STAGES-1 in the same cycle.
REQ-027 retired_cnt SHALL increment by 1 per retire event and wrap from 2^CNT_W-1 to 0.
REQ-028 occupancy SHALL be the combinational popcount of the stage valid bits.
REQ-029 out_valid, out_data and occupancy SHALL be driven from registers only, with no combinational path from inputs.

Reset
REQ-030 With reset=1 at an edge, all valid bits SHALL become 0, all data registers 0, and retired_cnt 0, overriding flush, freeze and load.
REQ-031 After reset, out_valid=0, out_data=0, occupancy=0 and retired_cnt=0, and in_ready SHALL equal NOT OR(freeze).
REQ-032 Reset asserted mid-stream SHALL drop all in-flight items without counting them as retired.

Structure
REQ-033 Package pipe_pkg SHALL hold the default constants (PIPE_DATA_W=32, PIPE_STAGES=5, PIPE_CNT_W=32) and the stage_t struct {valid, data}.
REQ-034 Sub-module pipe_stage_slot SHALL implement one stage (inputs load, bubble, clear, d; outputs q_valid, q_data), instantiated STAGES times via generate.

Verification (STAGES=5, DATA_W=32)
REQ-035 Scenario: reset, then push 0x0, 0x4, 0x8 in consecutive cycles from cycle 0 -> out_data 0x0/0x4/0x8 in cycles 5/6/7, and retired_cnt=3 in cycle 8.
REQ-036 Scenario: stream running, freeze=5'b00100 for 2 cycles -> in_ready=0 for 2 cycles, stages 0-2 hold, and 2 bubbles reach the output with no payload lost or duplicated.
REQ-037 Scenario: full pipe, flush=1, flush_depth=2 -> next cycle occupancy=3; the flushed payloads never appear on out_data.
REQ-038 Scenario: flush with flush_depth=5 and freeze=5'b10000 in the same cycle -> occupancy=0 next cycle, and retired_cnt unchanged (no retire because the output stage is frozen).
REQ-039 Scenario: CNT_W=4, retire 17 items -> retired_cnt=1.
REQ-040 Scenario: reset asserted with occupancy=5 -> next cycle occupancy=0, out_valid=0 and retired_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults and the stage record type for the pipe_stage_chain slice.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_STAGES = 5;
  localparam int PIPE_CNT_W  = 32;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage: a valid bit plus a payload register that only moves on load.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic              clear,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear only kills the valid bit; the payload keeps whatever the advance gave it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = d_valid;
      data_d  = d;
    end else if (bubble) begin
      valid_d = 1'b0;
    end
    if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES stage slots with per-stage freeze, youngest-first flush,
// occupancy popcount and a wrapping retired-item counter.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int STAGES = PIPE_STAGES,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic [STAGES-1:0]          freeze,
  input  logic                       flush,
  input  logic [$clog2(STAGES+1)-1:0] flush_depth,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           retired_cnt
);

  localparam int DEPTH_W = $clog2(STAGES + 1);

  if (STAGES < 2) begin : gBadStages
    $error("pipe_stage_chain: STAGES must be at least 2");
  end

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] stageLoad;
  logic [STAGES-1:0] stageBubble;
  logic [STAGES-1:0] stageClear;
  logic [STAGES-1:0] srcValid;
  logic [STAGES-1:0] qValid;
  logic [DATA_W-1:0] srcData [STAGES];
  logic [DATA_W-1:0] qData   [STAGES];
  logic [DEPTH_W-1:0] occ;
  logic [CNT_W-1:0]   retiredCnt_q, retiredCnt_d;
  logic               retire;

  // A frozen stage also holds every stage feeding it, so hold is a suffix-OR of freeze.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = freeze[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold[i] = hold[i+1] | freeze[i];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : gStage
    if (i == 0) begin : gHead
      assign srcValid[i]    = in_valid;
      assign srcData[i]     = in_data;
      assign stageLoad[i]   = ~hold[i];
      assign stageBubble[i] = 1'b0;
    end else begin : gBody
      assign srcValid[i]    = qValid[i-1];
      assign srcData[i]     = qData[i-1];
      assign stageLoad[i]   = ~hold[i] & ~hold[i-1];
      assign stageBubble[i] = ~hold[i] & hold[i-1];
    end

    assign stageClear[i] = flush && (int'(flush_depth) > i);

    pipe_stage_slot #(
      .DATA_W(DATA_W)
    ) uSlot (
      .clk     (clk),
      .reset   (reset),
      .load    (stageLoad[i]),
      .bubble  (stageBubble[i]),
      .clear   (stageClear[i]),
      .d_valid (srcValid[i]),
      .d       (srcData[i]),
      .q_valid (qValid[i]),
      .q_data  (qData[i])
    );
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ = occ + DEPTH_W'(qValid[i]);
    end
  end

  // An item leaving the last stage counts even if a flush clears that stage on the same edge.
  assign retire = qValid[STAGES-1] & ~freeze[STAGES-1];

  always_comb begin
    retiredCnt_d = retiredCnt_q;
    if (retire) begin
      retiredCnt_d = retiredCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retiredCnt_q <= '0;
    end else begin
      retiredCnt_q <= retiredCnt_d;
    end
  end

  assign in_ready    = ~hold[0];
  assign out_valid   = qValid[STAGES-1];
  assign out_data    = qData[STAGES-1];
  assign occupancy   = occ;
  assign retired_cnt = retiredCnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (STAGES=5, DATA_W=32, CNT_W=4 to exercise wrap).
module tb_pipe_stage_chain;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [4:0]  freeze;
  logic        flush;
  logic [2:0]  flush_depth;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  occupancy;
  logic [3:0]  retired_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic        gapWatch = 1'b0;
  int          bubbles = 0;

  pipe_stage_chain #(
    .DATA_W(32),
    .STAGES(5),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .freeze     (freeze),
    .flush      (flush),
    .flush_depth(flush_depth),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs; items the bench expects stage 0 to keep go into the scoreboard.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] frz,
                               input logic fl, input logic [2:0] fd);
    in_valid    = v;
    in_data     = d;
    freeze      = frz;
    flush       = fl;
    flush_depth = fd;
    #1;
    checkOutput("in_ready", in_ready, ~|frz);
    if (v && !reset && frz == 5'd0 && !(fl && fd != 3'd0)) expQ.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 3'd0);
  endtask

  // Compare every item leaving the output stage against the oldest expected item.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (out_valid === 1'b1 && freeze[4] === 1'b0) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_nonempty", 64'd0, 64'd1);
        end else begin
          logic [31:0] expData;
          expData = expQ.pop_front();
          checkOutput("out_data", out_data, expData);
        end
      end
      if (gapWatch && out_valid === 1'b0 && expQ.size() > 0) bubbles++;
    end
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    freeze      = '0;
    flush       = 1'b0;
    flush_depth = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_retired", retired_cnt, 0);

    $display("[TB] latency scenario");
    applyStimulus(1'b1, 32'h0, 5'd0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h4, 5'd0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h8, 5'd0, 1'b0, 3'd0);
    idle(2);
    checkOutput("lat_valid_c5", out_valid, 1);
    checkOutput("lat_data_c5", out_data, 32'h0);
    checkOutput("lat_occ_c5", occupancy, 3);
    idle(1);
    checkOutput("lat_data_c6", out_data, 32'h4);
    idle(1);
    checkOutput("lat_data_c7", out_data, 32'h8);
    idle(1);
    checkOutput("lat_retired_c8", retired_cnt, 3);
    checkOutput("lat_valid_c8", out_valid, 0);

    $display("[TB] freeze scenario");
    bubbles = 0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 32'h100 + 32'(k * 4), 5'd0, 1'b0, 3'd0);
      if (k == 4) gapWatch = 1'b1;
    end
    applyStimulus(1'b1, 32'h1FC, 5'b00100, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h1FC, 5'b00100, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h11C, 5'd0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h120, 5'd0, 1'b1, 3'd0);
    applyStimulus(1'b1, 32'h124, 5'd0, 1'b0, 3'd0);
    idle(10);
    gapWatch = 1'b0;
    checkOutput("frz_bubbles", bubbles, 2);
    checkOutput("frz_sb_drained", expQ.size(), 0);
    checkOutput("frz_retired", retired_cnt, 13);

    $display("[TB] partial flush scenario");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'h300 + 32'(k), 5'd0, 1'b0, 3'd0);
    checkOutput("fl2_occ_full", occupancy, 5);
    void'(expQ.pop_back());
    applyStimulus(1'b1, 32'h3FF, 5'd0, 1'b1, 3'd2);
    checkOutput("fl2_occ_after", occupancy, 3);
    idle(8);
    checkOutput("fl2_sb_drained", expQ.size(), 0);
    checkOutput("cnt_wrap", retired_cnt, 1);

    $display("[TB] full flush with frozen output");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'h400 + 32'(k), 5'd0, 1'b0, 3'd0);
    checkOutput("fl5_occ_full", occupancy, 5);
    expQ.delete();
    applyStimulus(1'b1, 32'h4FF, 5'b10000, 1'b1, 3'd5);
    checkOutput("fl5_occ_after", occupancy, 0);
    checkOutput("fl5_out_valid", out_valid, 0);
    checkOutput("fl5_retired", retired_cnt, 1);

    $display("[TB] oversize flush depth");
    applyStimulus(1'b1, 32'h500, 5'd0, 1'b0, 3'd0);
    applyStimulus(1'b1, 32'h504, 5'd0, 1'b0, 3'd0);
    void'(expQ.pop_back());
    void'(expQ.pop_back());
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 3'd7);
    checkOutput("fl7_occ_after", occupancy, 0);
    idle(6);
    checkOutput("fl7_sb_drained", expQ.size(), 0);
    checkOutput("fl7_retired", retired_cnt, 1);

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'h600 + 32'(k), 5'd0, 1'b0, 3'd0);
    checkOutput("rst2_occ_full", occupancy, 5);
    reset = 1'b1;
    expQ.delete();
    applyStimulus(1'b1, 32'h6FF, 5'd0, 1'b1, 3'd3);
    reset = 1'b0;
    checkOutput("rst2_occ", occupancy, 0);
    checkOutput("rst2_out_valid", out_valid, 0);
    checkOutput("rst2_out_data", out_data, 0);
    checkOutput("rst2_retired", retired_cnt, 0);
    applyStimulus(1'b0, 32'h0, 5'b00010, 1'b0, 3'd0);
    idle(6);
    checkOutput("rst2_sb_empty", expQ.size(), 0);
    checkOutput("rst2_retired_end", retired_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
